// File: rtl/cm0_rst_req_seq.sv
// cm0_rst_req_seq: multi-channel reset-request send stage.
// Each channel output is a plain flop. A per-channel counter holds the request
// high for a minimum time after the input drops, and a shared sequencer lets
// channels go low one at a time with a minimum spacing between releases.
// Optional feature macro: CM0_RST_REQ_CASCADE_EN (strict low-to-high release
// order, and an asserted channel pulls every higher channel back into reset).
module cm0_rst_req_seq #(
  parameter int NUM_CH  = 4,
  parameter int STRETCH = 8,
  parameter int STAGGER = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] RSTREQIN,
  output logic [NUM_CH-1:0] RSTREQOUT,
  output logic              ALLCLR
);

  localparam int CW = $clog2(STRETCH + 1);
  localparam int GW = $clog2(STAGGER + 1);

  typedef enum logic {IDLE, GAP} seq_state_t;

  seq_state_t        state, state_nxt;
  logic [GW-1:0]     gap, gap_nxt;
  logic [CW-1:0]     cnt [NUM_CH];
  logic [NUM_CH:0]   out_ext;
  logic [NUM_CH-1:0] out_below;
  logic [NUM_CH-1:0] req_eff;
  logic [NUM_CH-1:0] ready;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] next_out;
  logic              found;

  assign out_ext   = {RSTREQOUT, 1'b0};
  assign out_below = out_ext[NUM_CH-1:0];

  // Effective request per channel and which channels could be released now.
  // The live input is used, so a request arriving in the release cycle wins.
  always_comb begin
    req_eff = RSTREQIN;
    ready   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef CM0_RST_REQ_CASCADE_EN
      req_eff[i] = RSTREQIN[i] | out_below[i];
      ready[i]   = RSTREQOUT[i] & ~req_eff[i] & (cnt[i] == '0) & ~out_below[i];
`else
      ready[i]   = RSTREQOUT[i] & ~req_eff[i] & (cnt[i] == '0);
`endif
    end
  end

  // Sequencer state register: the gap counter spaces out successive releases.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      gap   <= '0;
    end else begin
      state <= state_nxt;
      gap   <= gap_nxt;
    end
  end

  // Sequencer next state: any grant opens a gap unless spacing is one cycle.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap;
    case (state)
      IDLE: begin
        if ((|ready) && (STAGGER > 1)) begin
          state_nxt = GAP;
          gap_nxt   = GW'(STAGGER - 1);
        end
      end
      GAP: begin
        gap_nxt = gap - GW'(1);
        if (gap == GW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer output: grant the lowest-index ready channel while idle.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (state == IDLE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ready[i] && !found) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  // Next output value: requests always win, a grant is the only way to go low.
  always_comb begin
    next_out = RSTREQOUT;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_eff[i])    next_out[i] = 1'b1;
      else if (grant[i]) next_out[i] = 1'b0;
    end
  end

  // Output flops and stretch counters; counters reload on request, hold at zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RSTREQOUT <= '1;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= CW'(STRETCH);
    end else begin
      RSTREQOUT <= next_out;
      for (int i = 0; i < NUM_CH; i++) begin
        if (req_eff[i])
          cnt[i] <= CW'(STRETCH);
        else if (RSTREQOUT[i] && (cnt[i] != '0))
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  // All-clear flag: rises only after a full cycle with every output low,
  // and drops on the same edge that any output goes back high.
  always_ff @(posedge CLK) begin
    if (RST) ALLCLR <= 1'b0;
    else     ALLCLR <= (next_out == '0) && (RSTREQOUT == '0);
  end

endmodule

// File: tb/tb_cm0_rst_req_seq.sv
// Self-checking bench for cm0_rst_req_seq (NUM_CH=4, STRETCH=8).
// A second instance with STAGGER=1 runs on the same inputs.
// Honours CM0_RST_REQ_CASCADE_EN when defined.
module tb_cm0_rst_req_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] RSTREQIN;
  logic [3:0] RSTREQOUT;
  logic       ALLCLR;
  logic [3:0] RSTREQOUT1;
  logic       ALLCLR1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] expOut;
    logic       expAllclr;
    logic [3:0] expOut1;
    logic       expAllclr1;
  } vec_t;

  vec_t resetTable [17];

  cm0_rst_req_seq #(.NUM_CH(4), .STRETCH(8), .STAGGER(2)) dut (
    .CLK(CLK), .RST(RST), .RSTREQIN(RSTREQIN),
    .RSTREQOUT(RSTREQOUT), .ALLCLR(ALLCLR)
  );

  cm0_rst_req_seq #(.NUM_CH(4), .STRETCH(8), .STAGGER(1)) dut1 (
    .CLK(CLK), .RST(RST), .RSTREQIN(RSTREQIN),
    .RSTREQOUT(RSTREQOUT1), .ALLCLR(ALLCLR1)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Drive inputs, take one edge, then settle away from the edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] req);
    RST      = rst;
    RSTREQIN = req;
    @(posedge CLK);
    #1;
  endtask

  // Compare one instance's outputs against expected values.
  task automatic checkOutput(input string name, input logic [3:0] actOut, input logic actAllclr,
                             input logic [3:0] expOut, input logic expAllclr);
    checks++;
    if (actOut !== expOut || actAllclr !== expAllclr) begin
      failures++;
      $display("[TB] FAIL %s: got RSTREQOUT=%b ALLCLR=%b, want RSTREQOUT=%b ALLCLR=%b",
               name, actOut, actAllclr, expOut, expAllclr);
    end
  endtask

  // One edge with RST low, checking the STAGGER=2 instance.
  task automatic step(input string name, input logic [3:0] req,
                      input logic [3:0] expOut, input logic expAllclr);
    applyStimulus(1'b0, req);
    checkOutput(name, RSTREQOUT, ALLCLR, expOut, expAllclr);
  endtask

  // Several edges with a constant input and constant expectation.
  task automatic hold(input string name, input int n, input logic [3:0] req,
                      input logic [3:0] expOut, input logic expAllclr);
    for (int k = 0; k < n; k++) step(name, req, expOut, expAllclr);
  endtask

`ifndef CM0_RST_REQ_CASCADE_EN
  // Reset followed by the full staggered release, checked on both instances.
  task automatic runResetTable(input string tag);
    for (int k = 0; k < 17; k++) begin
      applyStimulus(resetTable[k].rst, resetTable[k].req);
      checkOutput($sformatf("%s_e%0d", tag, k), RSTREQOUT, ALLCLR,
                  resetTable[k].expOut, resetTable[k].expAllclr);
      checkOutput($sformatf("%s_s1_e%0d", tag, k), RSTREQOUT1, ALLCLR1,
                  resetTable[k].expOut1, resetTable[k].expAllclr1);
    end
  endtask
`endif

  initial begin
    resetTable[0] = '{1'b1, 4'h0, 4'hF, 1'b0, 4'hF, 1'b0};
    for (int k = 1; k <= 8; k++) resetTable[k] = '{1'b0, 4'h0, 4'hF, 1'b0, 4'hF, 1'b0};
    resetTable[9]  = '{1'b0, 4'h0, 4'hE, 1'b0, 4'hE, 1'b0};
    resetTable[10] = '{1'b0, 4'h0, 4'hE, 1'b0, 4'hC, 1'b0};
    resetTable[11] = '{1'b0, 4'h0, 4'hC, 1'b0, 4'h8, 1'b0};
    resetTable[12] = '{1'b0, 4'h0, 4'hC, 1'b0, 4'h0, 1'b0};
    resetTable[13] = '{1'b0, 4'h0, 4'h8, 1'b0, 4'h0, 1'b1};
    resetTable[14] = '{1'b0, 4'h0, 4'h8, 1'b0, 4'h0, 1'b1};
    resetTable[15] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1};
    resetTable[16] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b1};

    RST      = 1'b1;
    RSTREQIN = 4'h0;
    repeat (2) @(posedge CLK);
    #1;

`ifndef CM0_RST_REQ_CASCADE_EN
    $display("[TB] reset release");
    runResetTable("rstrel");

    $display("[TB] single pulse on ch2");
    step("pulse_rise", 4'b0100, 4'b0100, 1'b0);
    hold("pulse_stretch", 8, 4'b0000, 4'b0100, 1'b0);
    step("pulse_release", 4'b0000, 4'b0000, 1'b0);
    step("pulse_allclr", 4'b0000, 4'b0000, 1'b1);

    $display("[TB] simultaneous ch0 and ch3");
    applyStimulus(1'b0, 4'b1001);
    checkOutput("sim_rise", RSTREQOUT, ALLCLR, 4'b1001, 1'b0);
    checkOutput("sim_s1_rise", RSTREQOUT1, ALLCLR1, 4'b1001, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 4'b0000);
      checkOutput("sim_stretch", RSTREQOUT, ALLCLR, 4'b1001, 1'b0);
    end
    applyStimulus(1'b0, 4'b0000);
    checkOutput("sim_rel_ch0", RSTREQOUT, ALLCLR, 4'b1000, 1'b0);
    checkOutput("sim_s1_rel_ch0", RSTREQOUT1, ALLCLR1, 4'b1000, 1'b0);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("sim_gap", RSTREQOUT, ALLCLR, 4'b1000, 1'b0);
    checkOutput("sim_s1_rel_ch3", RSTREQOUT1, ALLCLR1, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("sim_rel_ch3", RSTREQOUT, ALLCLR, 4'b0000, 1'b0);
    checkOutput("sim_s1_allclr", RSTREQOUT1, ALLCLR1, 4'b0000, 1'b1);
    step("sim_allclr", 4'b0000, 4'b0000, 1'b1);

    $display("[TB] request in the release cycle");
    step("late_rise", 4'b0110, 4'b0110, 1'b0);
    hold("late_stretch", 8, 4'b0000, 4'b0110, 1'b0);
    step("late_collide", 4'b0010, 4'b0010, 1'b0);
    hold("late_restretch", 8, 4'b0000, 4'b0010, 1'b0);
    step("late_release", 4'b0000, 4'b0000, 1'b0);
    step("late_allclr", 4'b0000, 4'b0000, 1'b1);

    $display("[TB] reset mid-stretch");
    step("ms_rise", 4'b0011, 4'b0011, 1'b0);
    hold("ms_stretch", 4, 4'b0000, 4'b0011, 1'b0);
    runResetTable("midstretch");

    $display("[TB] reset mid-gap");
    step("mg_rise", 4'b0011, 4'b0011, 1'b0);
    hold("mg_stretch", 8, 4'b0000, 4'b0011, 1'b0);
    step("mg_rel_ch0", 4'b0000, 4'b0010, 1'b0);
    runResetTable("midgap");
`else
    $display("[TB] cascade reset release");
    applyStimulus(1'b1, 4'h0);
    checkOutput("crst_reset", RSTREQOUT, ALLCLR, 4'hF, 1'b0);
    hold("crst_stretch0", 8, 4'b0000, 4'b1111, 1'b0);
    hold("crst_rel0", 9, 4'b0000, 4'b1110, 1'b0);
    hold("crst_rel1", 9, 4'b0000, 4'b1100, 1'b0);
    hold("crst_rel2", 9, 4'b0000, 4'b1000, 1'b0);
    step("crst_rel3", 4'b0000, 4'b0000, 1'b0);
    step("crst_allclr", 4'b0000, 4'b0000, 1'b1);

    $display("[TB] cascade pulse on ch1");
    step("casc_bit1", 4'b0010, 4'b0010, 1'b0);
    step("casc_bit2", 4'b0000, 4'b0110, 1'b0);
    hold("casc_bit3", 7, 4'b0000, 4'b1110, 1'b0);
    hold("casc_rel1", 9, 4'b0000, 4'b1100, 1'b0);
    hold("casc_rel2", 9, 4'b0000, 4'b1000, 1'b0);
    step("casc_rel3", 4'b0000, 4'b0000, 1'b0);
    step("casc_allclr", 4'b0000, 4'b0000, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
